// File: rtl/sound_pkg.sv
// Shared constants for the sound path: lead-voice note periods at 50 MHz,
// pattern entry field layout and the sequencer state encoding.
package sound_pkg;

  localparam int unsigned NOTE_W    = 24;
  localparam int unsigned FIELD_W   = 4;
  localparam int unsigned GATE_LSB  = 0;
  localparam int unsigned NOTE_LSB  = 4;
  localparam logic [3:0]  NOTE_REST = 4'hF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Equal-tempered C4..D5 periods in 50 MHz clock cycles.
  function automatic logic [NOTE_W-1:0] note_period(input logic [FIELD_W-1:0] idx);
    logic [NOTE_W-1:0] p;
    case (idx)
      4'd0:    p = NOTE_W'(191110);
      4'd1:    p = NOTE_W'(180388);
      4'd2:    p = NOTE_W'(170265);
      4'd3:    p = NOTE_W'(160705);
      4'd4:    p = NOTE_W'(151685);
      4'd5:    p = NOTE_W'(143172);
      4'd6:    p = NOTE_W'(135139);
      4'd7:    p = NOTE_W'(127551);
      4'd8:    p = NOTE_W'(120395);
      4'd9:    p = NOTE_W'(113636);
      4'd10:   p = NOTE_W'(107259);
      4'd11:   p = NOTE_W'(101239);
      4'd12:   p = NOTE_W'(95556);
      4'd13:   p = NOTE_W'(90193);
      4'd14:   p = NOTE_W'(85131);
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable step down-counter: loads L-1 = ((tempo+1) << TICK_SHIFT) - 1 and
// reports expiry plus whether the next count value falls inside the gap window.
module step_timer #(
  parameter int unsigned TICK_SHIFT = 16,
  parameter int unsigned GAP_CYCLES = 16384
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       run,
  input  logic [7:0] tempo,
  output logic       expire,
  output logic       in_gap
);

  localparam int unsigned CNT_W = 8 + TICK_SHIFT;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // (tempo+1) << TICK_SHIFT minus one is tempo followed by TICK_SHIFT ones.
  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = {tempo, {TICK_SHIFT{1'b1}}};
    end else if (run && (count != '0)) begin
      count_nxt = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

  assign expire = (count == '0);
  // Evaluated on the value the counter takes this edge, so a registered gate lines up with it.
  assign in_gap = (count_nxt < CNT_W'(GAP_CYCLES));

endmodule

// File: rtl/note_sequencer.sv
// Pattern sequencer: plays a RAM of gate masks / lead notes, one step per
// tempo-derived interval, driving the voice gates and the lead pwm period.
module note_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned NUM_STEPS  = 16,
  parameter int unsigned PERIOD_W   = 24,
  parameter int unsigned TICK_SHIFT = 16,
  parameter int unsigned GAP_CYCLES = 16384,
  localparam int unsigned STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  input  logic                gap_en,
  input  logic [7:0]          tempo,
  input  logic                wr_en,
  input  logic [STEP_W-1:0]   wr_addr,
  input  logic [7:0]          wr_data,
  output logic [3:0]          gate,
  output logic [PERIOD_W-1:0] lead_period,
  output logic [PERIOD_W-1:0] lead_compare,
  output logic [STEP_W-1:0]   step_idx,
  output logic                step_pulse,
  output logic                running
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

  state_t              state;
  state_t              state_nxt;
  logic                load;
  logic [STEP_W-1:0]   load_idx;
  logic                expire;
  logic                in_gap;

  logic [7:0]          ram [NUM_STEPS];
  logic [7:0]          entry;
  logic [3:0]          mask_q;
  logic [3:0]          mask_nxt;
  logic [3:0]          gate_nxt;
  logic [PERIOD_W-1:0] period_nxt;
  logic [PERIOD_W-1:0] compare_nxt;
  logic [STEP_W-1:0]   idx_nxt;
  logic                pulse_nxt;

  step_timer #(
    .TICK_SHIFT (TICK_SHIFT),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_step_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .run    (state == ST_RUN),
    .tempo  (tempo),
    .expire (expire),
    .in_gap (in_gap)
  );

  // Next state and step-load decision; stop beats both start and expiry.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_idx  = (state == ST_RUN) ? STEP_W'(step_idx + STEP_W'(1)) : '0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nxt = ST_RUN;
          load      = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (expire) begin
          if ((step_idx == LAST_STEP) && !loop) begin
            state_nxt = ST_IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output next values; the RAM read sees pre-write data for same-cycle writes.
  always_comb begin
    entry       = ram[load_idx];
    mask_nxt    = mask_q;
    period_nxt  = lead_period;
    compare_nxt = lead_compare;
    idx_nxt     = step_idx;
    pulse_nxt   = 1'b0;
    gate_nxt    = '0;
    if (load) begin
      idx_nxt   = load_idx;
      pulse_nxt = 1'b1;
      mask_nxt  = entry[GATE_LSB +: FIELD_W];
      if (entry[NOTE_LSB +: FIELD_W] == NOTE_REST) begin
        mask_nxt[3] = 1'b0;
      end else begin
        period_nxt  = PERIOD_W'(note_period(entry[NOTE_LSB +: FIELD_W]));
        compare_nxt = period_nxt >> 1;
      end
    end
    if ((state_nxt == ST_RUN) && !(gap_en && in_gap)) begin
      gate_nxt = mask_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      mask_q       <= '0;
      gate         <= '0;
      lead_period  <= '0;
      lead_compare <= '0;
      step_idx     <= '0;
      step_pulse   <= 1'b0;
      running      <= 1'b0;
      for (int i = 0; i < int'(NUM_STEPS); i++) begin
        ram[i] <= '0;
      end
    end else begin
      state        <= state_nxt;
      mask_q       <= mask_nxt;
      gate         <= gate_nxt;
      lead_period  <= period_nxt;
      lead_compare <= compare_nxt;
      step_idx     <= idx_nxt;
      step_pulse   <= pulse_nxt;
      running      <= (state_nxt == ST_RUN);
      if (wr_en) begin
        ram[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer with short steps (TICK_SHIFT=2, GAP_CYCLES=1):
// a step-level reference model plus hand-computed spot checks.
module tb_note_sequencer;

  localparam int TS  = 2;
  localparam int GAP = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic        gap_en = 1'b0;
  logic [7:0]  tempo = 8'd0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0;
  logic [7:0]  wr_data = 8'd0;
  logic [3:0]  gate;
  logic [23:0] lead_period;
  logic [23:0] lead_compare;
  logic [3:0]  step_idx;
  logic        step_pulse;
  logic        running;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  note_sequencer #(
    .NUM_STEPS  (16),
    .PERIOD_W   (24),
    .TICK_SHIFT (TS),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .loop         (loop),
    .gap_en       (gap_en),
    .tempo        (tempo),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .gate         (gate),
    .lead_period  (lead_period),
    .lead_compare (lead_compare),
    .step_idx     (step_idx),
    .step_pulse   (step_pulse),
    .running      (running)
  );

  // Reference model: which step plays, how many cycles of it remain, what it shows.
  int note_tab [15] = '{191110, 180388, 170265, 160705, 151685, 143172, 135139,
                        127551, 120395, 113636, 107259, 101239, 95556, 90193, 85131};
  int pat [16];
  bit m_run;
  bit m_pulse;
  bit m_gapen;
  int m_idx;
  int m_rem;
  int m_mask;
  int m_period;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) pat[i] = 0;
    m_run = 0; m_pulse = 0; m_gapen = 0;
    m_idx = 0; m_rem = 0; m_mask = 0; m_period = 0;
  endfunction

  function automatic int exp_gate();
    if (!m_run) return 0;
    if (m_gapen && (m_rem - 1) < GAP) return 0;
    return m_mask;
  endfunction

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n) begin
      bit do_load;
      int nidx;
      int e;
      do_load = 0;
      nidx = 0;
      m_pulse = 0;
      if (!m_run) begin
        if (start && !stop) do_load = 1;
      end else if (stop) begin
        m_run = 0;
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          if (m_idx == 15 && !loop) m_run = 0;
          else begin
            do_load = 1;
            nidx = (m_idx + 1) % 16;
          end
        end
      end
      if (do_load) begin
        m_run = 1;
        m_idx = nidx;
        m_rem = (int'(tempo) + 1) * (1 << TS);
        e = pat[nidx];
        m_mask = e % 16;
        if (e / 16 == 15) m_mask = m_mask % 8;
        else m_period = note_tab[e / 16];
        m_pulse = 1;
      end
      if (wr_en) pat[wr_addr] = int'(wr_data);
      m_gapen = gap_en;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_gate", int'(gate), exp_gate());
      check("m_running", int'(running), int'(m_run));
      check("m_pulse", int'(step_pulse), int'(m_pulse));
      check("m_step_idx", int'(step_idx), m_idx);
      check("m_period", int'(lead_period), m_period);
      check("m_compare", int'(lead_compare), m_period / 2);
    end
  end

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    int p1;
    int p2;
    int n;
    model_reset();
    #2 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gate", int'(gate), 0);
    check("rst_running", int'(running), 0);
    check("rst_period", int'(lead_period), 0);
    rst_n = 1'b1;

    // Two-entry pattern, looping, no gap.
    wr(4'd0, 8'h9F);
    wr(4'd1, 8'hF3);
    loop = 1'b1; gap_en = 1'b0; tempo = 8'd0;
    pulse_start();
    check("s0_pulse", int'(step_pulse), 1);
    check("s0_gate", int'(gate), 15);
    check("s0_period", int'(lead_period), 113636);
    check("s0_compare", int'(lead_compare), 56818);
    repeat (4) @(negedge clk);
    check("s1_idx", int'(step_idx), 1);
    check("s1_gate", int'(gate), 3);
    check("s1_period_held", int'(lead_period), 113636);
    repeat (60) @(negedge clk);
    check("wrap_idx", int'(step_idx), 0);
    check("wrap_pulse", int'(step_pulse), 1);
    check("wrap_gate", int'(gate), 15);
    do_stop();
    check("stop_running", int'(running), 0);
    check("stop_gate", int'(gate), 0);

    // Articulation gap: last cycle of each step silent.
    gap_en = 1'b1;
    pulse_start();
    check("gap_c1", int'(gate), 15);
    repeat (2) @(negedge clk);
    check("gap_c3", int'(gate), 15);
    @(negedge clk);
    check("gap_c4", int'(gate), 0);
    @(negedge clk);
    check("gap_s1", int'(gate), 3);
    repeat (6) @(negedge clk);
    do_stop();
    gap_en = 1'b0;

    // Tempo change mid-step applies from the next step only.
    tempo = 8'd0;
    pulse_start();
    tempo = 8'd1;
    p1 = -1; p2 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (step_pulse) begin
        if (p1 < 0) p1 = k;
        else if (p2 < 0) p2 = k;
      end
    end
    check("tempo_step0_len", p1, 4);
    check("tempo_step1_len", p2 - p1, 8);
    do_stop();
    tempo = 8'd0;

    // One-shot pass through 16 steps.
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h01);
    loop = 1'b0;
    pulse_start();
    n = 0;
    while (running && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("oneshot_len", n, 64);
    check("oneshot_gate_after", int'(gate), 0);

    // start+stop together in idle stays idle.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("startstop_running", int'(running), 0);
    check("startstop_pulse", int'(step_pulse), 0);

    // Stop inside step 1 holds step_idx and lead.
    pulse_start();
    repeat (5) @(negedge clk);
    do_stop();
    check("midstop_running", int'(running), 0);
    check("midstop_gate", int'(gate), 0);
    check("midstop_idx", int'(step_idx), 1);
    check("midstop_period", int'(lead_period), 191110);

    // Asynchronous reset between edges, then replay of the cleared pattern.
    loop = 1'b1;
    wr(4'd0, 8'h9F);
    pulse_start();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_gate", int'(gate), 0);
    check("arst_running", int'(running), 0);
    check("arst_period", int'(lead_period), 0);
    check("arst_idx", int'(step_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    check("replay_running", int'(running), 1);
    check("replay_gate", int'(gate), 0);
    check("replay_period", int'(lead_period), 191110);
    repeat (8) @(negedge clk);
    do_stop();
    @(negedge clk);
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
